// File: rtl/alu_mdu_seq_if.sv
// alu_mdu_seq_if: request/response handshake bundle for the sequential EX-stage ALU/MDU.
// master = issuing pipeline stage, slave = alu_mdu_seq.
interface alu_mdu_seq_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [4:0]      op;
   logic [XLEN-1:0] rdataA;
   logic [XLEN-1:0] rdataB;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] ALU_result;
   logic            busy;

   modport master (
      output in_valid, op, rdataA, rdataB, out_ready,
      input  in_ready, out_valid, ALU_result, busy
   );

   modport slave (
      input  in_valid, op, rdataA, rdataB, out_ready,
      output in_ready, out_valid, ALU_result, busy
   );
endinterface

// File: rtl/alu_mdu_seq.sv
// alu_mdu_seq: sequential RV32I/RV64I execute ALU with RV M-extension.
// Base ops finish in one cycle; multiply iterates shift-add, divide iterates
// restoring division, both on operand magnitudes with sign fix-up at the end.
// Optional macro ALU_MDU_FAST_MUL_EN: MUL* use a single-cycle combinational
// multiplier (IDLE->FIX->DONE); divide stays iterative in both builds.
module alu_mdu_seq #(
   parameter int XLEN = 32,
   parameter int SHW  = $clog2(XLEN)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   alu_mdu_seq_if.slave bus
);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_MUL  = 3'd1;
   localparam logic [2:0] ST_DIV  = 3'd2;
   localparam logic [2:0] ST_FIX  = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

   localparam logic [4:0] OP_ADD    = 5'h00;
   localparam logic [4:0] OP_SUB    = 5'h01;
   localparam logic [4:0] OP_SLL    = 5'h02;
   localparam logic [4:0] OP_SLT    = 5'h03;
   localparam logic [4:0] OP_SLTU   = 5'h04;
   localparam logic [4:0] OP_XOR    = 5'h05;
   localparam logic [4:0] OP_SRL    = 5'h06;
   localparam logic [4:0] OP_SRA    = 5'h07;
   localparam logic [4:0] OP_OR     = 5'h08;
   localparam logic [4:0] OP_AND    = 5'h09;
   localparam logic [4:0] OP_PASSB  = 5'h0A;
   localparam logic [4:0] OP_MUL    = 5'h10;
   localparam logic [4:0] OP_MULH   = 5'h11;
   localparam logic [4:0] OP_MULHSU = 5'h12;
   localparam logic [4:0] OP_MULHU  = 5'h13;
   localparam logic [4:0] OP_DIV    = 5'h14;
   localparam logic [4:0] OP_DIVU   = 5'h15;
   localparam logic [4:0] OP_REM    = 5'h16;
   localparam logic [4:0] OP_REMU   = 5'h17;

   logic [2:0]      state;
   logic [SHW-1:0]  cnt;
   logic [XLEN-1:0] hi;        // product high half / partial remainder
   logic [XLEN-1:0] lo;        // multiplier+product low half / dividend+quotient
   logic [XLEN-1:0] m;         // multiplicand / divisor magnitude
   logic [4:0]      op_r;
   logic            sa_r;      // operand A was negative under signed interpretation
   logic            sb_r;      // operand B was negative under signed interpretation
   logic            out_valid_r;
   logic            busy_r;
   logic [XLEN-1:0] result_r;

   logic            is_mul;
   logic            is_div;
   logic            a_signed;
   logic            b_signed;
   logic            neg_a;
   logic            neg_b;
   logic [XLEN-1:0] mag_a;
   logic [XLEN-1:0] mag_b;
   logic [SHW-1:0]  shamt;
   logic [XLEN-1:0] base_res;
   logic            accept;

   logic [XLEN:0]   mul_sum;
   logic [XLEN:0]   div_shift;
   logic [XLEN:0]   div_diff;

   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo;
   logic [XLEN-1:0]   rem;
   logic [XLEN-1:0]   fix_res;

`ifdef ALU_MDU_FAST_MUL_EN
   logic [2*XLEN-1:0] fast_prod;
   assign fast_prod = (2*XLEN)'(mag_a) * (2*XLEN)'(mag_b);
`endif

   assign bus.out_valid  = out_valid_r;
   assign bus.busy       = busy_r;
   assign bus.ALU_result = result_r;

   // DONE is the only state holding a result, so "IDLE with the result being
   // consumed" is expressed as DONE && out_ready; this enables back-to-back issue.
   assign bus.in_ready = !flush &&
                         ((state == ST_IDLE) || ((state == ST_DONE) && bus.out_ready));
   assign accept       = bus.in_valid && bus.in_ready;

   assign shamt  = bus.rdataB[SHW-1:0];
   assign is_mul = (bus.op[4:2] == 3'b100);
   assign is_div = (bus.op[4:2] == 3'b101);

   // Operand signedness per M op and magnitude extraction.
   always_comb begin
      a_signed = 1'b0;
      b_signed = 1'b0;
      case (bus.op)
         OP_MULH:   begin a_signed = 1'b1; b_signed = 1'b1; end
         OP_MULHSU: begin a_signed = 1'b1; b_signed = 1'b0; end
         OP_DIV:    begin a_signed = 1'b1; b_signed = 1'b1; end
         OP_REM:    begin a_signed = 1'b1; b_signed = 1'b1; end
         default:   begin a_signed = 1'b0; b_signed = 1'b0; end
      endcase
      neg_a = a_signed && bus.rdataA[XLEN-1];
      neg_b = b_signed && bus.rdataB[XLEN-1];
      mag_a = neg_a ? -bus.rdataA : bus.rdataA;
      mag_b = neg_b ? -bus.rdataB : bus.rdataB;
   end

   // Single-cycle base integer operations.
   always_comb begin
      base_res = '0;
      case (bus.op)
         OP_ADD:   base_res = bus.rdataA + bus.rdataB;
         OP_SUB:   base_res = bus.rdataA - bus.rdataB;
         OP_SLL:   base_res = bus.rdataA << shamt;
         OP_SLT:   base_res = {{(XLEN-1){1'b0}}, $signed(bus.rdataA) < $signed(bus.rdataB)};
         OP_SLTU:  base_res = {{(XLEN-1){1'b0}}, bus.rdataA < bus.rdataB};
         OP_XOR:   base_res = bus.rdataA ^ bus.rdataB;
         OP_SRL:   base_res = bus.rdataA >> shamt;
         OP_SRA:   base_res = $signed(bus.rdataA) >>> shamt;
         OP_OR:    base_res = bus.rdataA | bus.rdataB;
         OP_AND:   base_res = bus.rdataA & bus.rdataB;
         OP_PASSB: base_res = bus.rdataB;
         default:  base_res = '0;
      endcase
   end

   // One shift-add step and one restoring-division step.
   always_comb begin
      mul_sum   = lo[0] ? ({1'b0, hi} + {1'b0, m}) : {1'b0, hi};
      div_shift = {hi, lo[XLEN-1]};
      div_diff  = div_shift - {1'b0, m};
   end

   // Sign correction and result select. The DIV overflow case (most-negative / -1)
   // falls out of the magnitude arithmetic; only divide-by-zero needs an override,
   // and a zero divisor already leaves the dividend magnitude in the remainder.
   always_comb begin
      prod = {hi, lo};
      if (sa_r ^ sb_r) prod = -prod;
      quo = lo;
      if (sa_r ^ sb_r) quo = -quo;
      rem = hi;
      if (sa_r) rem = -rem;
      if (m == '0) quo = '1;
      case (op_r)
         OP_MUL:                       fix_res = prod[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:              fix_res = quo;
         default:                      fix_res = rem;
      endcase
   end

   // Control FSM, iteration datapath and result register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         hi          <= '0;
         lo          <= '0;
         m           <= '0;
         op_r        <= '0;
         sa_r        <= 1'b0;
         sb_r        <= 1'b0;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
         result_r    <= '0;
      end else if (flush) begin
         state       <= ST_IDLE;
         out_valid_r <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if ((state == ST_DONE) && bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  state       <= ST_IDLE;
               end
               if (accept) begin
                  op_r <= bus.op;
                  sa_r <= neg_a;
                  sb_r <= neg_b;
                  if (is_mul) begin
                     out_valid_r <= 1'b0;
                     busy_r      <= 1'b1;
                     m           <= mag_a;
`ifdef ALU_MDU_FAST_MUL_EN
                     hi          <= fast_prod[2*XLEN-1:XLEN];
                     lo          <= fast_prod[XLEN-1:0];
                     state       <= ST_FIX;
`else
                     hi          <= '0;
                     lo          <= mag_b;
                     cnt         <= SHW'(XLEN-1);
                     state       <= ST_MUL;
`endif
                  end else if (is_div) begin
                     out_valid_r <= 1'b0;
                     busy_r      <= 1'b1;
                     hi          <= '0;
                     lo          <= mag_a;
                     m           <= mag_b;
                     cnt         <= SHW'(XLEN-1);
                     state       <= ST_DIV;
                  end else begin
                     result_r    <= base_res;
                     out_valid_r <= 1'b1;
                     state       <= ST_DONE;
                  end
               end
            end
            ST_MUL: begin
               hi  <= mul_sum[XLEN:1];
               lo  <= {mul_sum[0], lo[XLEN-1:1]};
               cnt <= cnt - 1'b1;
               if (cnt == '0) state <= ST_FIX;
            end
            ST_DIV: begin
               if (!div_diff[XLEN]) begin
                  hi <= div_diff[XLEN-1:0];
                  lo <= {lo[XLEN-2:0], 1'b1};
               end else begin
                  hi <= div_shift[XLEN-1:0];
                  lo <= {lo[XLEN-2:0], 1'b0};
               end
               cnt <= cnt - 1'b1;
               if (cnt == '0) state <= ST_FIX;
            end
            ST_FIX: begin
               result_r    <= fix_res;
               out_valid_r <= 1'b1;
               busy_r      <= 1'b0;
               state       <= ST_DONE;
            end
            default: begin
               state       <= ST_IDLE;
               out_valid_r <= 1'b0;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

endmodule
